keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Drives the row lines of the 4x4 keypad matrix interface in response to the column strobes from the keypad scanner. It acts as the "keypad side" of that interface.
- Used in place of a physical keypad for loopback, self-test and bench stimulus.
- Accepts one key-press request at a time over a valid/ready handshake. It holds the key for a programmable number of scan frames, then releases it for a programmable gap, then signals done.
- The key code uses the same 4-bit encoding the scanner reports, so a requested code round-trips unchanged.

Parameters:
- HOLD_SCANS, 2, number of scan frames the key stays pressed; legal range 1..15.
- GAP_SCANS, 2, number of scan frames the key stays released before done; legal range 1..15.

Ports:
- clk  in  1  system clock; col is synchronous to this clock.
- rst_n  in  1  asynchronous active-low reset.
- key_code  in  4  requested key; [3:2] row index, [1:0] column index.
- key_valid  in  1  request valid.
- key_ready  out  1  emulator can accept a request.
- col  in  4  column strobe from the scanner; one-hot, or 0000 between frames.
- row  out  4  row response to the scanner; one-hot or 0000.
- busy  out  1  a request is in progress (PRESS or GAP).
- done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, row=0000, done=0, busy=0, key_ready=1 after release, frame counter=0, latched code=0, col_q=0000. A reset mid-press drops row to 0000 immediately, without waiting for clk.
- Index to one-hot decode, applied to both the row index and the column index:
  - 01 -> 0001
  - 10 -> 0010
  - 11 -> 0100
  - 00 -> 1000
- R = decode(code[3:2]); C = decode(code[1:0]).
- Frame tick:
  - col_q holds col registered by one cycle.
  - tick = (col==0000) && (col_q!=0000), i.e. the scanner has returned to its idle strobe.
- key_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE:
  - row=0000.
  - If key_valid && key_ready: latch key_code, clear the counter, go to PRESS.
- PRESS:
  - row is registered each cycle: row <= (col==C) ? R : 0000.
  - This gives one cycle of latency from col to row.
  - Any col value not equal to C, including non-one-hot values, gives 0000.
  - On tick: counter+1. If counter+1==HOLD_SCANS, go to GAP, clear the counter and force row <= 0000 in the same edge.
- GAP:
  - row=0000.
  - On tick: counter+1. If counter+1==GAP_SCANS, go to IDLE and pulse done for exactly one cycle. That cycle is the first cycle in IDLE, so key_ready=1 in the same cycle as done.
- Simultaneous events:
  - A request is accepted in the done cycle when key_valid=1. The next press starts immediately, and done still pulses.
  - A tick in the same cycle as acceptance is ignored; counting starts with the next tick.
- key_valid while busy is ignored; the requester must hold it until key_ready.
- key_code changes while busy have no effect.
- The counter is 4 bits and never wraps, because the transition fires at the parameter value.
- If col stays at 0000 forever, no ticks occur and the emulator remains in PRESS or GAP indefinitely. There is no timeout.
- The scanner samples row at the end of each 16-cycle column dwell, so the 1-cycle row latency is always absorbed.

Test Plan:
- Reset, then code 0110, HOLD=2, GAP=2, scanner connected:
  - row=0001 only when col=0010 (one cycle delayed).
  - Scanner reports keypressed=0110, active=1.
  - After 2 ticks row stays 0000 and active falls after the empty sweep.
  - done pulses after 2 more ticks.
- Code 0000: row=1000 only while col=1000. Scanner reports 0000 with active=1, which distinguishes it from the idle 0000 with active=0.
- Sweep all 16 codes back-to-back, with key_valid held high and re-driven in each done cycle: the scanner output sequence equals the request sequence, and no request is lost or duplicated.
- Bench-driven col, code 1011: drive col=0100 and col=1100 (illegal) → row=0011? No: R=decode(10)=0010, C=decode(11)=0100.
  - col=0100 → row=0010 next cycle.
  - col=1100 → row=0000.
  - col=0001 → row=0000.
- Assert rst_n=0 asynchronously mid-PRESS while row=0010: row goes to 0000 before the next clk edge. After release: key_ready=1, busy=0, and no done pulse.
- Hold col=0000 forever after acceptance: no ticks occur, busy stays 1, and done never pulses. Then start scanning: exactly HOLD+GAP ticks after scanning begins, done pulses once.

Source files
------------

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// keypad_emulator : keypad side of the 4x4 matrix interface; answers column
// strobes with the row of a requested key for HOLD scan frames, then GAP frames.
// Revision 1.0
// ============================================================================
module keypad_emulator #(
  parameter int HOLD_SCANS = 2,
  parameter int GAP_SCANS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] HOLD_N = 4'(HOLD_SCANS);
  localparam logic [3:0] GAP_N  = 4'(GAP_SCANS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] code;
  logic [3:0] col_q;
  logic [3:0] row_oh;
  logic [3:0] col_oh;
  logic [3:0] cnt_inc;
  logic       tick;

  // Index 00 maps to the highest line so the scanner's code round-trips.
  function automatic logic [3:0] decode(input logic [1:0] idx);
    logic [3:0] oh;
    unique case (idx)
      2'b01:   oh = 4'b0001;
      2'b10:   oh = 4'b0010;
      2'b11:   oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

  assign row_oh    = decode(code[3:2]);
  assign col_oh    = decode(code[1:0]);
  assign tick      = (col == 4'b0000) && (col_q != 4'b0000);
  assign cnt_inc   = cnt + 4'd1;
  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= 4'b0000;
      done  <= 1'b0;
      cnt   <= 4'd0;
      code  <= 4'd0;
      col_q <= 4'b0000;
    end else begin
      col_q <= col;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          row <= 4'b0000;
          if (key_valid) begin
            code  <= key_code;
            cnt   <= 4'd0;
            state <= PRESS;
          end
        end
        PRESS: begin
          row <= (col == col_oh) ? row_oh : 4'b0000;
          if (tick) begin
            cnt <= cnt_inc;
            if (cnt_inc == HOLD_N) begin
              state <= GAP;
              cnt   <= 4'd0;
              row   <= 4'b0000;
            end
          end
        end
        GAP: begin
          row <= 4'b0000;
          if (tick) begin
            cnt <= cnt_inc;
            if (cnt_inc == GAP_N) begin
              state <= IDLE;
              cnt   <= 4'd0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          row   <= 4'b0000;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// tb_keypad_emulator : scoreboard bench for keypad_emulator with a bench-side
// scanner model and directed column/reset stimulus.
// Revision 1.0
// ============================================================================
module tb_keypad_emulator;

  localparam int HOLD  = 2;
  localparam int GAP   = 2;
  localparam int DWELL = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [3:0] key_code  = 4'd0;
  logic       key_valid = 1'b0;
  logic [3:0] col       = 4'b0000;
  logic       key_ready;
  logic [3:0] row;
  logic       busy;
  logic       done;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  bit         req_finished = 1'b0;
  logic [3:0] code_q[$];
  logic [3:0] row_q[$];

  keypad_emulator #(
    .HOLD_SCANS (HOLD),
    .GAP_SCANS  (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // done must coincide with the first IDLE cycle
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_with_ready", key_ready, 1);
    end
  end

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0001: return 2'b01;
      4'b0010: return 2'b10;
      4'b0100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; key_valid = 1'b0; col = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic request(input logic [3:0] c);
    key_code = c; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'hF;
    check("accept_busy", busy, 1);
  endtask

  task automatic drive_col(input logic [3:0] c, input logic [3:0] exp);
    col = c;
    row_q.push_back(exp);
    @(negedge clk);
    check($sformatf("row@col=%b", c), row, row_q.pop_front());
  endtask

  task automatic tick_frame();
    col = 4'b0010;
    @(negedge clk);
    col = 4'b0000;
    @(negedge clk);
  endtask

  task automatic scan_frame(inout bit prev_key);
    bit         key;
    logic [3:0] got;
    key = 1'b0; got = 4'd0;
    for (int c = 0; c < 4; c++) begin
      col = 4'(1 << c);
      repeat (DWELL) @(negedge clk);
      if (row != 4'b0000) begin
        key = 1'b1;
        got = {oh2idx(row), oh2idx(col)};
      end
    end
    col = 4'b0000;
    repeat (2) @(negedge clk);
    if (key && !prev_key) begin
      check("sb_nonempty", code_q.size() > 0, 1);
      if (code_q.size() > 0) check("scan_code", got, code_q.pop_front());
    end
    prev_key = key;
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_row", row, 4'b0000);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", key_ready, 1);

    // Code 0000: pressed only under the highest column strobe
    request(4'b0000);
    drive_col(4'b1000, 4'b1000);
    drive_col(4'b0001, 4'b0000);
    drive_col(4'b1000, 4'b1000);
    drive_col(4'b0100, 4'b0000);
    do_reset();

    // Code 1011: R=0010, C=0100; non-one-hot strobes give nothing
    request(4'b1011);
    drive_col(4'b0100, 4'b0010);
    drive_col(4'b1100, 4'b0000);
    drive_col(4'b0001, 4'b0000);
    drive_col(4'b0100, 4'b0010);

    // Asynchronous reset mid-press, between clock edges
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_row", row, 4'b0000);
    check("async_rst_busy", busy, 0);
    col = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", key_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_no_done", done_cnt - d0, 0);

    // Stalled scanner: no ticks, no progress
    request(4'b0110);
    d0 = done_cnt;
    repeat (50) @(negedge clk);
    check("stall_busy", busy, 1);
    check("stall_no_done", done_cnt - d0, 0);
    for (int f = 1; f <= HOLD + GAP; f++) begin
      col = 4'b0010;
      @(negedge clk);
      check($sformatf("frame%0d_row", f), row, (f <= HOLD) ? 4'b0001 : 4'b0000);
      col = 4'b0000;
      @(negedge clk);
      check($sformatf("frame%0d_done", f), done, (f == HOLD + GAP) ? 1 : 0);
    end
    check("stall_ready", key_ready, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("stall_done_count", done_cnt - d0, 1);

    // Back-to-back requests against the scanner model
    d0 = done_cnt;
    fork
      begin : requester
        logic [3:0] codes[$];
        int         w;
        codes.push_back(4'b0110);
        for (int i = 0; i < 16; i++) codes.push_back(4'(i));
        foreach (codes[k]) begin
          key_code  = codes[k];
          key_valid = 1'b1;
          w = 0;
          while (!key_ready && w < 3000) begin
            @(negedge clk);
            w++;
          end
          check("req_ready", key_ready, 1);
          code_q.push_back(codes[k]);
          @(negedge clk);
        end
        key_valid = 1'b0;
        req_finished = 1'b1;
      end
      begin : scanner
        bit prev_key;
        int frames;
        prev_key = 1'b0;
        frames = 0;
        while (!(req_finished && code_q.size() == 0 && !busy) && frames < 400) begin
          scan_frame(prev_key);
          frames++;
        end
        check("sweep_complete", frames < 400, 1);
      end
    join
    check("sweep_done_count", done_cnt - d0, 17);
    check("sb_drained", code_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
